// File: rtl/note_dispenser.sv
// Dispense controller: feeds a note mechanism one note at a time over a four-phase req/ack handshake.
// The highest denomination is always served first. It reports remaining notes, completion and ack-timeout faults.
module note_dispenser #(
  parameter int CW          = 9,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] c50,
  input  logic [CW-1:0] c20,
  input  logic [CW-1:0] c10,
  input  logic [CW-1:0] c5,
  input  logic          pause,
  input  logic          ack,
  input  logic          clear,
  output logic          req,
  output logic [1:0]    denom,
  output logic          active,
  output logic          done,
  output logic          fault,
  output logic [CW+1:0] remaining
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = CW + 2;
  localparam logic [TW-1:0] TMO_LIMIT = TW'(ACK_TIMEOUT);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SELECT   = 3'd1;
  localparam logic [2:0] S_REQ      = 3'd2;
  localparam logic [2:0] S_WAIT_REL = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_FAULT    = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] n50_q, n50_d, n20_q, n20_d, n10_q, n10_d, n5_q, n5_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    denom_q, denom_d;
  logic          req_q, req_d;
  logic          all_zero;

  assign all_zero = (n50_q == '0) && (n20_q == '0) && (n10_q == '0) && (n5_q == '0);

  always_comb begin
    state_d = state_q;
    n50_d   = n50_q;
    n20_d   = n20_q;
    n10_d   = n10_q;
    n5_d    = n5_q;
    tmo_d   = tmo_q;
    denom_d = denom_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          n50_d   = c50;
          n20_d   = c20;
          n10_d   = c10;
          n5_d    = c5;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (!pause) begin
          if (all_zero) begin
            state_d = S_DONE;
          end else begin
            if (n50_q != '0)      denom_d = 2'd0;
            else if (n20_q != '0) denom_d = 2'd1;
            else if (n10_q != '0) denom_d = 2'd2;
            else                  denom_d = 2'd3;
            tmo_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // An ack on the same edge the limit is reached still counts as a dispensed note.
        if (ack) begin
          case (denom_q)
            2'd0:    n50_d = n50_q - 1'b1;
            2'd1:    n20_d = n20_q - 1'b1;
            2'd2:    n10_d = n10_q - 1'b1;
            default: n5_d  = n5_q - 1'b1;
          endcase
          state_d = S_WAIT_REL;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TMO_LIMIT) state_d = S_FAULT;
        end
      end
      S_WAIT_REL: begin
        if (!ack) state_d = S_SELECT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (clear) begin
          n50_d   = '0;
          n20_d   = '0;
          n10_d   = '0;
          n5_d    = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n50_q   <= '0;
      n20_q   <= '0;
      n10_q   <= '0;
      n5_q    <= '0;
      tmo_q   <= '0;
      denom_q <= 2'd0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n50_q   <= n50_d;
      n20_q   <= n20_d;
      n10_q   <= n10_d;
      n5_q    <= n5_d;
      tmo_q   <= tmo_d;
      denom_q <= denom_d;
      req_q   <= req_d;
    end
  end

  assign req       = req_q;
  assign denom     = denom_q;
  assign active    = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign done      = (state_q == S_DONE);
  assign fault     = (state_q == S_FAULT);
  assign remaining = RW'(n50_q) + RW'(n20_q) + RW'(n10_q) + RW'(n5_q);

endmodule
